// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   Serial transmitter. A byte offered on a valid/ready handshake is sent as an
//   asynchronous frame on txd: one start bit (0), eight data bits LSB first,
//   then one stop bit (1). Bit timing comes from an internal divider of
//   CLKS_PER_BIT system clocks per bit.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     When defined, an even-parity bit (XOR of the accepted byte) is sent
//     between data bit 7 and the stop bit, giving an 11-bit frame.
//     When undefined, the frame is plain 8N1 (10 bits).
//
// Handshake: a byte is accepted on a rising clk edge where tx_valid and
//   tx_ready are both high (tx_ready is only high in IDLE). tx_data is
//   sampled at that edge only; tx_valid seen while a frame is in progress
//   is ignored, and tx_valid need not be held once the edge has passed.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high reset
//   tx_data   in   [7:0] byte to send, sampled at acceptance
//   tx_valid  in   producer offers tx_data
//   tx_ready  out  idle and able to accept (registered)
//   txd       out  serial line, idles high (registered)
//   busy      out  frame in progress, always !tx_ready (registered)
//
// Parameter:
//   CLKS_PER_BIT  clocks per serial bit, must be >= 2
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       busy
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx: CLKS_PER_BIT must be 2 or more");
  end

  localparam int              DIV_W    = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  // Kept as a plain named register so checkers can bind to the FSM state.
  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
`ifdef UART_TX_PARITY_EN
  logic             parity_bit;
`endif

  // All outputs are registered: each transition also sets the txd level of
  // the bit being entered, so the line never depends on an input directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
      txd        <= 1'b1;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (tx_valid && tx_ready) begin
            shreg      <= tx_data;
            bit_idx    <= 3'd0;
            div_cnt    <= '0;
            state      <= S_START;
            txd        <= 1'b0;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^tx_data;
`endif
          end
        end

        default: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            case (state)
              S_START: begin
                state <= S_DATA;
                txd   <= shreg[0];
              end
              S_DATA: begin
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + 3'd1;
                if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state <= S_PARITY;
                  txd   <= parity_bit;
`else
                  state <= S_STOP;
                  txd   <= 1'b1;
`endif
                end else begin
                  // Next bit is the one about to land in shreg[0].
                  txd <= shreg[1];
                end
              end
`ifdef UART_TX_PARITY_EN
              S_PARITY: begin
                state <= S_STOP;
                txd   <= 1'b1;
              end
`endif
              S_STOP: begin
                state    <= S_IDLE;
                txd      <= 1'b1;
                tx_ready <= 1'b1;
                busy     <= 1'b0;
              end
              default: begin
                // Unreachable encodings recover to a clean idle line.
                state    <= S_IDLE;
                txd      <= 1'b1;
                tx_ready <= 1'b1;
                busy     <= 1'b0;
              end
            endcase
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//   Bench for uart_tx with CLKS_PER_BIT=4. Drivers push each accepted byte
//   into exp_q; a line monitor decodes txd at every falling clk edge, pops
//   the expected byte when a start bit appears and compares the whole
//   frame waveform against the frame built from the byte.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int N   = 4;
  localparam int CLK = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int WAIT_LIMIT = 2000;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       txd;
  logic       busy;

  uart_tx #(.CLKS_PER_BIT(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .txd      (txd),
    .busy     (busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #(CLK / 2) clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int frames_done = 0;
  int aborted     = 0;
  int n_sent      = 0;
  time acc_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic [FRAME_BITS-1:0] frame_of(input logic [7:0] b);
    logic [FRAME_BITS-1:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1 + i] = b[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    f[FRAME_BITS-1] = 1'b1;
    return f;
  endfunction

  // ---------------- monitor ----------------
  logic                  mon_active = 1'b0;
  logic                  post_check = 1'b0;
  int                    mon_cnt = 0;
  int                    mon_bad = 0;
  logic [7:0]            mon_exp = 8'h00;
  logic [7:0]            mon_rx  = 8'h00;
  logic [FRAME_BITS-1:0] mon_bits = '1;
  int                    hi_run = 0;
  int                    last_gap = 0;
  time                   last_start_t = 0;
  time                   prev_start_t = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (mon_active) aborted++;
      mon_active = 1'b0;
      post_check = 1'b0;
      hi_run     = 0;
    end else begin
      check("busy_is_not_ready", {31'd0, busy}, {31'd0, !tx_ready});
      if (post_check) begin
        check("idle_txd_after_frame", {31'd0, txd}, 32'd1);
        check("ready_after_frame", {31'd0, tx_ready}, 32'd1);
        post_check = 1'b0;
      end
      if (!mon_active && txd === 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_frame: start bit seen with empty queue at %0t", $time);
        end else begin
          mon_exp  = exp_q.pop_front();
          mon_bits = frame_of(mon_exp);
        end
        mon_active   = 1'b1;
        mon_cnt      = 0;
        mon_bad      = 0;
        mon_rx       = 8'h00;
        last_gap     = hi_run;
        prev_start_t = last_start_t;
        last_start_t = $time;
      end
      if (mon_active) begin
        if (txd !== mon_bits[mon_cnt / N] || tx_ready !== 1'b0) mon_bad++;
        if ((mon_cnt % N) == N / 2 && mon_cnt / N >= 1 && mon_cnt / N <= 8)
          mon_rx[mon_cnt / N - 1] = txd;
        mon_cnt++;
        if (mon_cnt == FRAME_BITS * N) begin
          check("frame_waveform_bad_samples", mon_bad, 32'd0);
          check("rx_byte", {24'd0, mon_rx}, {24'd0, mon_exp});
          frames_done++;
          mon_active = 1'b0;
          post_check = 1'b1;
        end
      end
      hi_run = (txd === 1'b1) ? hi_run + 1 : 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input string name);
    int n = 0;
    @(negedge clk);
    while (!(tx_ready === 1'b1 && !mon_active) && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, n < WAIT_LIMIT}, 32'd1);
  endtask

  // Offer one byte at a falling edge while idle; it is accepted at the next
  // rising edge. tx_data is scrambled right after acceptance.
  task automatic send_byte(input logic [7:0] b);
    wait_ready("send_wait_ready");
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    acc_t = $time;
    exp_q.push_back(b);
    n_sent++;
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic ready_latency(input string name);
    int n = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(($time - acc_t - CLK / 2) / CLK), 32'(FRAME_BITS * N));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #(1_000_000);
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int done_before;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    #1;
    check("reset_txd", {31'd0, txd}, 32'd1);
    check("reset_ready", {31'd0, tx_ready}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;

    // Single byte 0xA5: waveform by monitor, ready returns after one frame.
    send_byte(8'hA5);
    ready_latency("ready_latency_a5");

    // 0x07 has odd weight, so its parity bit is 1 when parity is enabled.
    send_byte(8'h07);
    ready_latency("ready_latency_07");

    // Back-to-back with tx_valid held: 0x00 then 0xFF.
    wait_ready("b2b_wait_ready");
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(8'h00);
    n_sent++;
    #1 tx_data = 8'hFF;
    begin
      int n = 0;
      @(negedge clk);
      while (tx_ready !== 1'b1 && n < WAIT_LIMIT) begin
        @(negedge clk);
        n++;
      end
      check("b2b_second_ready", {31'd0, n < WAIT_LIMIT}, 32'd1);
    end
    @(posedge clk);
    exp_q.push_back(8'hFF);
    n_sent++;
    #1 tx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("b2b_line_high_gap", last_gap, 32'(N + 1));
    check("b2b_start_spacing", 32'((last_start_t - prev_start_t) / CLK), 32'(FRAME_BITS * N + 1));

    // Request pulsed during DATA is ignored.
    send_byte(8'h5A);
    done_before = frames_done;
    repeat (3 * N) @(posedge clk);
    #1;
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    wait_ready("ignored_wait_idle");
    repeat (2 * FRAME_BITS * N) @(posedge clk);
    #1;
    check("ignored_queue_empty", exp_q.size(), 32'd0);
    check("ignored_one_frame", frames_done - done_before, 32'd1);
    check("ignored_no_activity", {31'd0, mon_active}, 32'd0);

    // Reset asserted between edges during data bit 3.
    send_byte(8'hC3);
    repeat (4 * N + 1) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("midreset_txd", {31'd0, txd}, 32'd1);
    check("midreset_ready", {31'd0, tx_ready}, 32'd1);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 tx_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("no_accept_in_reset", {31'd0, tx_ready}, 32'd1);
    check("aborted_frames", aborted, 32'd1);
    send_byte(8'h81);
    ready_latency("ready_latency_81");

    // Randomized bytes with ignored noise requests while busy.
    for (int i = 0; i < 16; i++) begin
      send_byte(8'($urandom));
      repeat ($urandom_range(1, 3)) begin
        repeat ($urandom_range(1, 8)) @(negedge clk);
        if (tx_ready === 1'b0) begin
          tx_valid = 1'b1;
          tx_data  = 8'($urandom);
          @(posedge clk);
          #1 tx_valid = 1'b0;
        end
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    wait_ready("final_wait_idle");
    repeat (4) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 32'd0);
    check("final_frame_count", frames_done, 32'(n_sent - 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
